// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the divide issue controller.
package div_ctrl_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] INST_DIV  = 3'b100;
  localparam logic [OP_W-1:0] INST_DIVU = 3'b101;
  localparam logic [OP_W-1:0] INST_REM  = 3'b110;
  localparam logic [OP_W-1:0] INST_REMU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_ctrl_state_t;

  // True for the four M-extension divide-class funct3 codes.
  function automatic logic is_div_op(input logic [OP_W-1:0] op);
    return (op == INST_DIV) || (op == INST_DIVU) ||
           (op == INST_REM) || (op == INST_REMU);
  endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Pipeline and divider signals of the divide issue controller.
interface div_ctrl_if
  import div_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned REG_ADDR_W = 5
);

  logic                  req_valid_i;
  logic [OP_W-1:0]       op_i;
  logic [WIDTH-1:0]      dividend_i;
  logic [WIDTH-1:0]      divisor_i;
  logic [REG_ADDR_W-1:0] rd_addr_i;
  logic                  flush_i;
  logic                  stall_o;
  logic                  wb_valid_o;
  logic [REG_ADDR_W-1:0] wb_addr_o;
  logic [WIDTH-1:0]      wb_data_o;
  logic                  div_valid_o;
  logic [OP_W-1:0]       div_op_o;
  logic [WIDTH-1:0]      div_dividend_o;
  logic [WIDTH-1:0]      div_divisor_o;
  logic [WIDTH-1:0]      div_data_i;
  logic                  div_ready_i;

  modport slave (
    input  req_valid_i, op_i, dividend_i, divisor_i, rd_addr_i, flush_i,
           div_data_i, div_ready_i,
    output stall_o, wb_valid_o, wb_addr_o, wb_data_o,
           div_valid_o, div_op_o, div_dividend_o, div_divisor_o
  );

  modport master (
    output req_valid_i, op_i, dividend_i, divisor_i, rd_addr_i, flush_i,
           div_data_i, div_ready_i,
    input  stall_o, wb_valid_o, wb_addr_o, wb_data_o,
           div_valid_o, div_op_o, div_dividend_o, div_divisor_o
  );

endinterface

// File: rtl/div_ctrl_cache.sv
// Single-entry result cache keyed on {op, dividend, divisor}.
module div_result_cache
  import div_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [OP_W-1:0]  lkp_op_i,
  input  logic [WIDTH-1:0] lkp_dividend_i,
  input  logic [WIDTH-1:0] lkp_divisor_i,
  output logic             lkp_hit_c,
  output logic [WIDTH-1:0] lkp_data_o,
  input  logic             fill_en_i,
  input  logic [OP_W-1:0]  fill_op_i,
  input  logic [WIDTH-1:0] fill_dividend_i,
  input  logic [WIDTH-1:0] fill_divisor_i,
  input  logic [WIDTH-1:0] fill_data_i
);

  logic             valid_q;
  logic [OP_W-1:0]  op_q;
  logic [WIDTH-1:0] dividend_q;
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH-1:0] data_q;

  // Entry storage; only a fill overwrites it, only reset invalidates it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q    <= 1'b0;
      op_q       <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      data_q     <= '0;
    end else if (fill_en_i) begin
      valid_q    <= 1'b1;
      op_q       <= fill_op_i;
      dividend_q <= fill_dividend_i;
      divisor_q  <= fill_divisor_i;
      data_q     <= fill_data_i;
    end
  end

  assign lkp_hit_c  = valid_q && (op_q == lkp_op_i) &&
                      (dividend_q == lkp_dividend_i) && (divisor_q == lkp_divisor_i);
  assign lkp_data_o = data_q;

endmodule

// File: rtl/div_ctrl.sv
// Issue-side controller for the iterative divider with a one-entry result cache.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  div_ctrl_if.slave  bus
);

  div_ctrl_state_t       state_q, state_d;
  logic [OP_W-1:0]       op_q;
  logic [WIDTH-1:0]      dividend_q;
  logic [WIDTH-1:0]      divisor_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [WIDTH-1:0]      result_q;
  logic                  wb_valid_q, wb_valid_d;
  logic                  accept_c;
  logic                  stall_c;
  logic                  ld_req, ld_hit, ld_div, fill_en;
  logic                  hit_c;
  logic [WIDTH-1:0]      hit_data;

  assign accept_c = bus.req_valid_i & is_div_op(bus.op_i) & ~bus.flush_i;

  div_result_cache #(.WIDTH(WIDTH)) u_cache (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .lkp_op_i        (bus.op_i),
    .lkp_dividend_i  (bus.dividend_i),
    .lkp_divisor_i   (bus.divisor_i),
    .lkp_hit_c       (hit_c),
    .lkp_data_o      (hit_data),
    .fill_en_i       (fill_en),
    .fill_op_i       (op_q),
    .fill_dividend_i (dividend_q),
    .fill_divisor_i  (divisor_q),
    .fill_data_i     (bus.div_data_i)
  );

  // Next-state, stall and load-enable decode.
  always_comb begin
    state_d    = state_q;
    stall_c    = 1'b0;
    ld_req     = 1'b0;
    ld_hit     = 1'b0;
    ld_div     = 1'b0;
    fill_en    = 1'b0;
    wb_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          stall_c = 1'b1;
          ld_req  = 1'b1;
          if (bus.rd_addr_i == '0) begin
            state_d = DONE;
          end else if (hit_c) begin
            ld_hit     = 1'b1;
            wb_valid_d = 1'b1;
            state_d    = DONE;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        stall_c = ~bus.flush_i;
        if (bus.flush_i) begin
          state_d = IDLE;
        end else if (bus.div_ready_i) begin
          ld_div     = 1'b1;
          fill_en    = 1'b1;
          wb_valid_d = (rd_q != '0);
          state_d    = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Request latch, result register and write-back strobe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q       <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      rd_q       <= '0;
      result_q   <= '0;
      wb_valid_q <= 1'b0;
    end else begin
      wb_valid_q <= wb_valid_d;
      if (ld_req) begin
        op_q       <= bus.op_i;
        dividend_q <= bus.dividend_i;
        divisor_q  <= bus.divisor_i;
        rd_q       <= bus.rd_addr_i;
      end
      if (ld_hit)      result_q <= hit_data;
      else if (ld_div) result_q <= bus.div_data_i;
    end
  end

  // Stall is forced low while reset is asserted so every output reads 0.
  assign bus.stall_o        = stall_c & rst_ni;
  assign bus.wb_valid_o     = wb_valid_q;
  assign bus.wb_addr_o      = rd_q;
  assign bus.wb_data_o      = result_q;
  assign bus.div_valid_o    = (state_q == BUSY);
  assign bus.div_op_o       = op_q;
  assign bus.div_dividend_o = dividend_q;
  assign bus.div_divisor_o  = divisor_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a behavioural iterative-divider model.
module tb_div_ctrl;

  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_REM  = 3'b110;
  localparam logic [2:0] OP_REMU = 3'b111;

  logic clk_i;
  logic rst_ni;
  int   n_cmp = 0;
  int   n_err = 0;
  int   mcnt;

  div_ctrl_if #(.WIDTH(32), .REG_ADDR_W(5)) bus ();

  div_ctrl #(.WIDTH(32), .REG_ADDR_W(5)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    int          wb_cyc;
    logic [31:0] data;
    int          stall;
    int          dv;
  } vec_t;

  // RISC-V M-extension reference results.
  function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      OP_DIV:  ref_div = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      OP_DIVU: ref_div = (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM:  ref_div = (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: ref_div = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 2;
    return 34;
  endfunction

  // Divider model: ready pulses lat cycles after valid rises; idle clears it.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mcnt            <= 0;
      bus.div_ready_i <= 1'b0;
      bus.div_data_i  <= '0;
    end else if (!bus.div_valid_o) begin
      mcnt            <= 0;
      bus.div_ready_i <= 1'b0;
    end else begin
      mcnt <= mcnt + 1;
      if (!bus.div_ready_i &&
          mcnt == lat(bus.div_op_o, bus.div_dividend_o, bus.div_divisor_o) - 1) begin
        bus.div_ready_i <= 1'b1;
        bus.div_data_i  <= ref_div(bus.div_op_o, bus.div_dividend_o, bus.div_divisor_o);
      end else begin
        bus.div_ready_i <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one request, hold it while stalled, and record what the DUT did.
  task automatic run_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output int wb_cyc, output logic [31:0] wb_data,
                         output logic [4:0] wb_addr, output int stall_n, output int dv_first,
                         output int wb_n);
    bit done = 0;
    wb_cyc = -1; wb_data = '0; wb_addr = '0; stall_n = 0; dv_first = -1; wb_n = 0;
    @(posedge clk_i); #1;
    bus.req_valid_i = 1'b1; bus.op_i = op; bus.dividend_i = a; bus.divisor_i = b;
    bus.rd_addr_i = rd;
    for (int c = 0; c < 80 && !done; c++) begin
      @(negedge clk_i);
      if (bus.stall_o) stall_n++;
      if (bus.div_valid_o && dv_first < 0) dv_first = c;
      if (bus.wb_valid_o) begin
        wb_n++;
        if (wb_cyc < 0) begin
          wb_cyc = c; wb_data = bus.wb_data_o; wb_addr = bus.wb_addr_o;
        end
      end
      if (c > 0 && !bus.stall_o) done = 1;
      @(posedge clk_i); #1;
    end
    bus.req_valid_i = 1'b0;
    @(negedge clk_i);
    if (bus.wb_valid_o) wb_n++;
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL run_req timeout: stall still %0b after 80 cycles, required release", bus.stall_o);
    end
  endtask

  task automatic do_vec(input vec_t v, input string tag);
    int wc, sn, dv, wn;
    logic [31:0] wd;
    logic [4:0]  wa;
    run_req(v.op, v.a, v.b, v.rd, wc, wd, wa, sn, dv, wn);
    chk({tag, " wb_cycle"}, 32'(wc), 32'(v.wb_cyc));
    chk({tag, " stall_cycles"}, 32'(sn), 32'(v.stall));
    chk({tag, " div_valid_first"}, 32'(dv), 32'(v.dv));
    chk({tag, " wb_count"}, 32'(wn), (v.wb_cyc >= 0) ? 32'd1 : 32'd0);
    if (v.wb_cyc >= 0) begin
      chk({tag, " wb_data"}, wd, v.data);
      chk({tag, " wb_addr"}, 32'(wa), 32'(v.rd));
    end
  endtask

  // Issue a miss and flush it at cycle fc.
  task automatic run_flush(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input int fc, input string tag);
    int wn = 0;
    @(posedge clk_i); #1;
    bus.req_valid_i = 1'b1; bus.op_i = op; bus.dividend_i = a; bus.divisor_i = b;
    bus.rd_addr_i = rd;
    for (int c = 0; c <= fc + 12; c++) begin
      if (c == fc) begin bus.flush_i = 1'b1; bus.req_valid_i = 1'b0; end
      if (c == fc + 1) bus.flush_i = 1'b0;
      @(negedge clk_i);
      if (c == fc) begin
        chk({tag, " stall_in_flush"}, 32'(bus.stall_o), 32'd0);
        chk({tag, " div_busy_at_flush"}, 32'(bus.div_valid_o), 32'd1);
        if (fc >= 35) chk({tag, " ready_coincident"}, 32'(bus.div_ready_i), 32'd1);
      end
      if (c == fc + 1) chk({tag, " div_valid_after"}, 32'(bus.div_valid_o), 32'd0);
      if (bus.wb_valid_o) wn++;
      @(posedge clk_i); #1;
    end
    chk({tag, " wb_count"}, 32'(wn), 32'd0);
  endtask

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{OP_DIV,  32'd100,        32'hFFFF_FFF9, 5'd5,  36, 32'hFFFF_FFF2, 36,  1};
    vecs[1]  = '{OP_DIV,  32'd100,        32'hFFFF_FFF9, 5'd5,   1, 32'hFFFF_FFF2,  1, -1};
    vecs[2]  = '{OP_REM,  32'd100,        32'hFFFF_FFF9, 5'd5,  36, 32'd2,         36,  1};
    vecs[3]  = '{OP_DIVU, 32'd100,        32'hFFFF_FFF9, 5'd6,  36, 32'd0,         36,  1};
    vecs[4]  = '{OP_DIVU, 32'd123,        32'd0,         5'd3,   4, 32'hFFFF_FFFF,  4,  1};
    vecs[5]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 5'd7,   4, 32'h8000_0000,  4,  1};
    vecs[6]  = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF, 5'd8,   4, 32'd0,          4,  1};
    vecs[7]  = '{OP_REMU, 32'd123,        32'd0,         5'd12,  4, 32'd123,        4,  1};
    vecs[8]  = '{OP_REM,  32'hFFFF_FF9C,  32'd7,         5'd13, 36, 32'hFFFF_FFFE, 36,  1};
    vecs[9]  = '{OP_REM,  32'hFFFF_FF9C,  32'd7,         5'd14,  1, 32'hFFFF_FFFE,  1, -1};
    vecs[10] = '{OP_DIV,  32'd50,         32'd5,         5'd0,  -1, 32'd0,          1, -1};
    vecs[11] = '{OP_DIVU, 32'd1000,       32'd10,        5'd20, 36, 32'd100,       36,  1};
    vecs[12] = '{OP_DIVU, 32'd1000,       32'd10,        5'd21,  1, 32'd100,        1, -1};

    rst_ni = 1'b0;
    bus.req_valid_i = 1'b0; bus.op_i = '0; bus.dividend_i = '0; bus.divisor_i = '0;
    bus.rd_addr_i = '0; bus.flush_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("reset stall", 32'(bus.stall_o), 32'd0);
    chk("reset wb_valid", 32'(bus.wb_valid_o), 32'd0);
    chk("reset div_valid", 32'(bus.div_valid_o), 32'd0);
    chk("reset wb_data", bus.wb_data_o, 32'd0);
    chk("reset wb_addr", 32'(bus.wb_addr_o), 32'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    for (int i = 0; i < 13; i++) do_vec(vecs[i], $sformatf("v%0d", i));

    // Non-divide funct3 is ignored.
    @(posedge clk_i); #1;
    bus.req_valid_i = 1'b1; bus.op_i = 3'b011; bus.dividend_i = 32'd9; bus.divisor_i = 32'd3;
    bus.rd_addr_i = 5'd4;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      chk($sformatf("nondiv c%0d stall", c), 32'(bus.stall_o), 32'd0);
      chk($sformatf("nondiv c%0d div_valid", c), 32'(bus.div_valid_o), 32'd0);
      @(posedge clk_i); #1;
    end
    bus.req_valid_i = 1'b0;

    // Flush mid-divide leaves the cache holding DIVU 1000/10.
    run_flush(OP_DIV, 32'd77, 32'd3, 5'd9, 10, "flush10");
    do_vec('{OP_DIVU, 32'd1000, 32'd10, 5'd22, 1, 32'd100, 1, -1}, "flush10 cache_kept");
    do_vec('{OP_DIV, 32'd77, 32'd3, 5'd9, 36, 32'd25, 36, 1}, "flush10 reissue");

    // Flush coincident with ready drops the result without filling the cache.
    run_flush(OP_DIV, 32'd200, 32'd7, 5'd10, 35, "flush35");
    do_vec('{OP_DIV, 32'd77, 32'd3, 5'd9, 1, 32'd25, 1, -1}, "flush35 cache_kept");
    do_vec('{OP_DIV, 32'd200, 32'd7, 5'd10, 36, 32'd28, 36, 1}, "flush35 reissue");

    // Reset mid-BUSY with the request still presented.
    @(posedge clk_i); #1;
    bus.req_valid_i = 1'b1; bus.op_i = OP_DIV; bus.dividend_i = 32'd300; bus.divisor_i = 32'd7;
    bus.rd_addr_i = 5'd11;
    repeat (10) begin @(posedge clk_i); #1; end
    chk("rst_mid busy_before", 32'(bus.div_valid_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("rst_mid stall", 32'(bus.stall_o), 32'd0);
    chk("rst_mid div_valid", 32'(bus.div_valid_o), 32'd0);
    chk("rst_mid wb_valid", 32'(bus.wb_valid_o), 32'd0);
    chk("rst_mid wb_addr", 32'(bus.wb_addr_o), 32'd0);
    chk("rst_mid wb_data", bus.wb_data_o, 32'd0);
    chk("rst_mid div_op", 32'(bus.div_op_o), 32'd0);
    chk("rst_mid div_dividend", bus.div_dividend_o, 32'd0);
    chk("rst_mid div_divisor", bus.div_divisor_o, 32'd0);
    @(posedge clk_i); #1;
    bus.req_valid_i = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    do_vec('{OP_DIV, 32'd200, 32'd7, 5'd10, 36, 32'd28, 36, 1}, "rst_mid cache_cleared");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
